// File: rtl/fphub_div_issue_queue.sv
// fphub_div_issue_queue: operand FIFO plus issue FSM in front of a HUB
// floating-point divider. Holds one operation at a time at the divider and
// returns results in acceptance order.
// Optional feature: define FPHUB_DIV_WATCHDOG_EN to add a WAIT-state watchdog
// that forces an error result after TIMEOUT cycles without div_finish.
`timescale 1ns/1ps

module fphub_div_issue_queue #(
    parameter int unsigned M       = 23,
    parameter int unsigned E       = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [M+E:0]               in_x,
    input  logic [M+E:0]               in_d,
    input  logic [TW-1:0]              in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [M+E:0]               out_res,
    output logic [TW-1:0]              out_tag,
    output logic                       out_err,
    output logic                       div_start,
    output logic [M+E:0]               div_x,
    output logic [M+E:0]               div_d,
    input  logic [M+E:0]               div_res,
    input  logic                       div_finish,
    input  logic                       div_computing,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int unsigned W  = M + E + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT} state_t;

    // Parameter sanity at elaboration
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_params
        $error("fphub_div_issue_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT nonzero");
    end

    logic [W-1:0]  r_mem_x   [DEPTH];
    logic [W-1:0]  r_mem_d   [DEPTH];
    logic [TW-1:0] r_mem_tag [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_in_ready;

    state_t        r_state;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_d;
    logic [TW-1:0] r_tag;
    logic [W-1:0]  r_out_res;
    logic [TW-1:0] r_out_tag;
    logic          r_out_valid;
    logic          r_div_start;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    // Pop happens only when the FSM moves into ISSUE from IDLE or from a completed OUT
    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = (r_count != '0) &&
                         ((r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign in_ready  = r_in_ready;
    assign count     = r_count;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_tag   = r_out_tag;
    assign div_start = r_div_start;
    assign div_x     = r_x;
    assign div_d     = r_d;

    // FIFO storage write; contents need no reset since pointers/count gate reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr]   <= in_x;
            r_mem_d[r_wr_ptr]   <= in_d;
            r_mem_tag[r_wr_ptr] <= in_tag;
        end
    end

    // FIFO pointers, occupancy and ready flag
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < CW'(DEPTH));
        end
    end

`ifdef FPHUB_DIV_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wd_cnt;
    logic           r_out_err;
    assign out_err = r_out_err;
`else
    assign out_err = 1'b0;
`endif

    // Issue FSM with registered divider and result outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_d         <= '0;
            r_tag       <= '0;
            r_out_res   <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
            r_div_start <= 1'b0;
            r_busy      <= 1'b0;
`ifdef FPHUB_DIV_WATCHDOG_EN
            r_wd_cnt    <= '0;
            r_out_err   <= 1'b0;
`endif
        end else begin
            r_div_start <= 1'b0;
            r_busy      <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= w_pop || div_computing;
                    if (w_pop) begin
                        r_x         <= r_mem_x[r_rd_ptr];
                        r_d         <= r_mem_d[r_rd_ptr];
                        r_tag       <= r_mem_tag[r_rd_ptr];
                        r_div_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
`ifdef FPHUB_DIV_WATCHDOG_EN
                    r_wd_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (div_finish) begin
                        r_out_res   <= div_res;
                        r_out_tag   <= r_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
`ifdef FPHUB_DIV_WATCHDOG_EN
                        r_out_err   <= 1'b0;
`endif
                    end
`ifdef FPHUB_DIV_WATCHDOG_EN
                    else if (r_wd_cnt == WDW'(TIMEOUT - 1)) begin
                        r_out_res   <= {r_x[W-1] ^ r_d[W-1], {(W-1){1'b1}}};
                        r_out_tag   <= r_tag;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WDW'(1);
                    end
`endif
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_x         <= r_mem_x[r_rd_ptr];
                            r_d         <= r_mem_d[r_rd_ptr];
                            r_tag       <= r_mem_tag[r_rd_ptr];
                            r_div_start <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end else begin
                            r_busy  <= div_computing;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fphub_div_issue_queue.sv
// Testbench for fphub_div_issue_queue: stub divider (res = x ^ d after L
// cycles), scoreboard queue filled at acceptance, monitor popping on handshake.
// Watchdog scenario is compiled in when FPHUB_DIV_WATCHDOG_EN is defined.
`timescale 1ns/1ps

module tb_fphub_div_issue_queue;

    localparam int unsigned M       = 23;
    localparam int unsigned E       = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TW      = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned W       = M + E + 1;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_d = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_res;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic          div_start;
    logic [W-1:0]  div_x;
    logic [W-1:0]  div_d;
    logic [W-1:0]  div_res = '0;
    logic          div_finish = 1'b0;
    logic          div_computing = 1'b0;
    logic [CW-1:0] count;
    logic          busy;

    fphub_div_issue_queue #(
        .M(M), .E(E), .DEPTH(DEPTH), .TW(TW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_d(in_d), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_err(out_err),
        .div_start(div_start), .div_x(div_x), .div_d(div_d),
        .div_res(div_res), .div_finish(div_finish), .div_computing(div_computing),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stub_lat = 33;
    int stub_cnt = 0;
    bit stub_pending = 1'b0;
    bit stub_never = 1'b0;
    bit stub_force = 1'b0;
    bit rdy_rand = 1'b0;
    int ov_cycles = 0;
    int ds_cycles = 0;
    int start_cyc = 0;
    logic [W-1:0] res_latch = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within bound (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation, wait for acceptance, record its expected result
    task automatic push(input logic [W-1:0] x, input logic [W-1:0] d, input logic [TW-1:0] tag);
        exp_t e;
        bit done = 1'b0;
        in_x = x; in_d = d; in_tag = tag; in_valid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.tag = tag;
                if (stub_never) begin
                    e.res = {x[W-1] ^ d[W-1], {(W-1){1'b1}}};
                    e.err = 1'b1;
                end else begin
                    e.res = x ^ d;
                    e.err = 1'b0;
                end
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) fail("push_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) fail("drain_timeout");
        tick();
        tick();
    endtask

    task automatic wait_ov(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) fail("out_valid_timeout");
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stub divider: finish pulse L cycles after div_start, result x ^ d
    always @(posedge clk) begin
        #1;
        if (!rst_l) begin
            stub_cnt      = 0;
            stub_pending  = 1'b0;
            div_finish    = 1'b0;
            div_computing = 1'b0;
        end else begin
            div_finish = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    div_finish   = 1'b1;
                    div_res      = res_latch;
                    stub_pending = 1'b0;
                end
            end
            if (div_start) begin
                ds_cycles++;
                start_cyc = cyc;
                chk("start_while_busy", 64'(stub_pending), 64'd0);
                if (!stub_never) begin
                    res_latch    = div_x ^ div_d;
                    stub_cnt     = (stub_lat != 0) ? stub_lat : int'($urandom_range(1, 8));
                    stub_pending = 1'b1;
                end
                if (stub_force) begin
                    div_finish = 1'b1;
                    div_res    = ~(div_x ^ div_d);
                end
            end
            div_computing = (stub_cnt > 0);
        end
    end

    // Random back-pressure on the result side
    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compare each handshaken result against the scoreboard head
    always @(negedge clk) begin
        if (rst_l) begin
            if (out_valid) begin
                ov_cycles++;
                chk("result_before_finish", 64'(stub_pending && !stub_never), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got res %0h tag %0h with empty scoreboard", out_res, out_tag);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_res", 64'(out_res), 64'(e.res));
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
                    chk("out_err", 64'(out_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset values while rst_l is held low
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res",   64'(out_res),   64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_div_x",     64'(div_x),     64'd0);
        chk("rst_div_d",     64'(div_d),     64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst_l = 1'b1;
        tick();

        // Single operation, L=33, minimum issue latency
        stub_lat = 33; ov_cycles = 0; ds_cycles = 0;
        push(32'h3F800000, 32'h40000000, 4'd3);
        chk("lat_no_start_yet", 64'(div_start), 64'd0);
        tick();
        chk("lat_start", 64'(div_start), 64'd1);
        chk("issue_div_x", 64'(div_x), 64'h3F800000);
        chk("issue_div_d", 64'(div_d), 64'h40000000);
        drain();
        chk("single_out_valid_cycles", 64'(ov_cycles), 64'd1);
        chk("single_start_pulses", 64'(ds_cycles), 64'd1);

        // L=1: finish in the first WAIT cycle
        stub_lat = 1;
        push(W'($urandom), W'($urandom), 4'd7);
        drain();

        // Finish pulsed during ISSUE must be ignored
        stub_lat = 5; stub_force = 1'b1;
        push(W'($urandom), W'($urandom), 4'd8);
        drain();
        stub_force = 1'b0;

        // Five back-to-back pushes fill the FIFO behind the one in flight
        stub_lat = 33;
        for (int t = 0; t < 5; t++) push(W'($urandom), W'($urandom), TW'(t));
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drain();

        // Result held under back-pressure, next issue right after release
        stub_lat = 3; out_ready = 1'b0;
        push(W'($urandom), W'($urandom), 4'd10);
        push(W'($urandom), W'($urandom), 4'd11);
        wait_ov(100);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_res", 64'(out_res), 64'(exp_q[0].res));
            chk("stall_tag", 64'(out_tag), 64'(exp_q[0].tag));
            chk("stall_no_start", 64'(div_start), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("release_issue", 64'(div_start), 64'd1);
        drain();

        // Asynchronous reset in WAIT with two entries queued
        stub_lat = 33;
        push(W'($urandom), W'($urandom), 4'd1);
        push(W'($urandom), W'($urandom), 4'd2);
        push(W'($urandom), W'($urandom), 4'd3);
        #2;
        rst_l = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_div_start", 64'(div_start), 64'd0);
        chk("arst_count",     64'(count),     64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd1);
        chk("arst_busy",      64'(busy),      64'd0);
        chk("arst_div_x",     64'(div_x),     64'd0);
        chk("arst_out_res",   64'(out_res),   64'd0);
        chk("arst_out_tag",   64'(out_tag),   64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        ov_cycles = 0; ds_cycles = 0;
        for (int i = 0; i < 40; i++) tick();
        chk("post_rst_no_result", 64'(ov_cycles), 64'd0);
        chk("post_rst_no_start", 64'(ds_cycles), 64'd0);
        stub_lat = 4;
        push(W'($urandom), W'($urandom), 4'd12);
        chk("post_rst_lat_no_start", 64'(div_start), 64'd0);
        tick();
        chk("post_rst_lat_start", 64'(div_start), 64'd1);
        drain();

        // Randomized traffic with random latency and back-pressure
        stub_lat = 0; rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) != 0) push(W'($urandom), W'($urandom), TW'($urandom));
            else tick();
        end
        drain();
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        tick();
        stub_lat = 33;

`ifdef FPHUB_DIV_WATCHDOG_EN
        // Divider never finishes: watchdog result after TIMEOUT WAIT cycles
        stub_never = 1'b1;
        push(32'hBF800000, 32'h40000000, 4'd9);
        wait_ov(300);
        chk("wd_latency", 64'(cyc - start_cyc), 64'(TIMEOUT + 1));
        chk("wd_res", 64'(out_res), 64'hFFFFFFFF);
        drain();
        stub_never = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
